dem_thoi_gian: RTL and testbench
================================

DEM_THOI_GIAN -- requirements
Module: dem_thoi_gian

Interface
REQ-001 Parameter CLK_HZ, default 50000000: input clock cycles per second; legal range 2 or more.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 set_en  input  1  high = time-setting mode; counting suspended.
REQ-005 set_sel  input  2  field to adjust: 00 hours, 01 minutes, 10 seconds, 11 none.
REQ-006 set_inc  input  1  single-cycle request to increment the selected field, sampled only while set_en=1.
REQ-007 hour_t, hour_u, min_t, min_u, sec_t, sec_u  output  4 each  BCD digits (tens/units), registered, each wired directly to one 7-segment decoder.
REQ-008 sec_pulse  output  1  one-cycle pulse on every one-second advance.
REQ-009 day_pulse  output  1  one-cycle pulse on the 23:59:59 -> 00:00:00 advance.

Function
REQ-010 Prescaler SHALL count 0..CLK_HZ-1 and wrap to 0; tick = 1 in the cycle the prescaler equals CLK_HZ-1.
REQ-011 While set_en=0, a tick SHALL advance the time by one second in the same edge that wraps the prescaler; sec_pulse SHALL be high in the cycle after that edge, for exactly one cycle.
REQ-012 Seconds SHALL count 00..59; 59 -> 00 SHALL carry +1 into minutes in the same edge.
REQ-013 Minutes SHALL count 00..59; 59 -> 00 with incoming carry SHALL carry +1 into hours in the same edge.
REQ-014 Hours SHALL count 00..23 (24-hour); 23 -> 00 with incoming carry SHALL produce day_pulse for one cycle, aligned with sec_pulse.
REQ-015 Units digits SHALL wrap 9 -> 0 with +1 to tens; hours units SHALL wrap 3 -> 0 only when hour_t=2.
REQ-016 Every output digit SHALL always be a valid BCD digit 0-9; time values outside 00:00:00-23:59:59 SHALL never appear.
REQ-017 While set_en=1, the prescaler SHALL be held at 0, no tick SHALL occur, and sec_pulse and day_pulse SHALL stay 0.
REQ-018 set_en=1 with set_inc=1 SHALL increment the selected field by one, modulo its range (hours 24, minutes 60, seconds 60), with no carry into other fields; result visible the next cycle.
REQ-019 set_inc with set_sel=11 or with set_en=0 SHALL be ignored.
REQ-020 Holding set_inc high for N cycles SHALL produce N increments (level-per-cycle; no edge detection inside the block).
REQ-021 If set_en rises in the same cycle as a tick, set_en SHALL win: no advance, prescaler cleared.
REQ-022 After set_en falls, the prescaler SHALL restart from 0, so the first advance occurs exactly CLK_HZ cycles later.
REQ-023 Seconds-field adjustment SHALL NOT reset the prescaler beyond the hold of REQ-017.

Reset
REQ-024 rst_n=0 SHALL immediately, without a clock, force all digits to 0 (00:00:00), prescaler to 0, and sec_pulse and day_pulse to 0.
REQ-025 Reset asserted mid-count or mid-setting SHALL abort the operation; no partial carry survives.
REQ-026 After rst_n rises, the first advance SHALL occur CLK_HZ cycles after the first active edge (with set_en=0).

Verification (CLK_HZ=4)
REQ-027 Release reset with set_en=0 -> sec_u goes 0->1 on the 4th edge after release; sec_pulse high for 1 cycle; then every 4 cycles.
REQ-028 Set 00:00:59 via set_inc, run one second -> 00:01:00; min_u=1, sec_t=0, sec_u=0; day_pulse=0.
REQ-029 Set 23:59:59, run one second -> all digits 0, sec_pulse=1 and day_pulse=1 in the same cycle.
REQ-030 set_en=1, set_sel=00, 25 set_inc pulses from 00 -> hours=01, minutes and seconds unchanged; no pulses emitted.
REQ-031 Assert set_en on the tick cycle at 00:00:05 -> stays 00:00:05; drop set_en -> 00:00:06 exactly 4 cycles later.
REQ-032 Pull rst_n low asynchronously at 12:34:56 between clock edges -> outputs read 00:00:00 before the next edge.

Source files
------------

// File: rtl/dem_thoi_gian.sv
// 24-hour BCD time-of-day counter driven by a CLK_HZ prescaler, with a field-setting mode.
// Digits and pulses are registered: an advance is visible the cycle after its tick; set_en freezes counting.
module dem_thoi_gian #(
   parameter int CLK_HZ = 50000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       set_en,
   input  logic [1:0] set_sel,
   input  logic       set_inc,
   output logic [3:0] hour_t,
   output logic [3:0] hour_u,
   output logic [3:0] min_t,
   output logic [3:0] min_u,
   output logic [3:0] sec_t,
   output logic [3:0] sec_u,
   output logic       sec_pulse,
   output logic       day_pulse
);

   localparam int PW = $clog2(CLK_HZ);
   localparam logic [PW-1:0] PS_LAST = PW'(CLK_HZ - 1);

   typedef struct packed {
      logic [3:0] t;
      logic [3:0] u;
   } bcd2_t;

   typedef enum logic [1:0] {
      SEL_HOUR = 2'b00,
      SEL_MIN  = 2'b01,
      SEL_SEC  = 2'b10,
      SEL_NONE = 2'b11
   } sel_e;

   // Comparisons use >= so any out-of-range pair folds back to a legal value on its next step.
   function automatic bcd2_t inc_mod60(input bcd2_t v);
      bcd2_t r;
      r = v;
      if (v.u >= 4'd9) begin
         r.u = 4'd0;
         r.t = (v.t >= 4'd5) ? 4'd0 : v.t + 4'd1;
      end else begin
         r.u = v.u + 4'd1;
      end
      return r;
   endfunction

   function automatic bcd2_t inc_mod24(input bcd2_t v);
      bcd2_t r;
      r = v;
      if ((v.t >= 4'd2 && v.u >= 4'd3) || v.t > 4'd2) begin
         r.t = 4'd0;
         r.u = 4'd0;
      end else if (v.u >= 4'd9) begin
         r.t = v.t + 4'd1;
         r.u = 4'd0;
      end else begin
         r.u = v.u + 4'd1;
      end
      return r;
   endfunction

   function automatic logic is_59(input bcd2_t v);
      return (v.t == 4'd5) && (v.u == 4'd9);
   endfunction

   bcd2_t          hour_q, min_q, sec_q;
   bcd2_t          hour_d, min_d, sec_d;
   logic [PW-1:0]  prescale, prescale_d;
   logic           tick, sec_carry, min_carry, day_wrap;

   always_comb begin
      hour_d     = hour_q;
      min_d      = min_q;
      sec_d      = sec_q;
      prescale_d = prescale + 1'b1;
      // set_en outranks a coincident tick: no advance, prescaler cleared
      tick       = (prescale == PS_LAST) && !set_en;
      sec_carry  = tick && is_59(sec_q);
      min_carry  = sec_carry && is_59(min_q);
      day_wrap   = min_carry && (hour_q.t == 4'd2) && (hour_q.u == 4'd3);

      if (set_en || prescale == PS_LAST) begin
         prescale_d = '0;
      end

      if (tick) begin
         sec_d = inc_mod60(sec_q);
         if (sec_carry) begin
            min_d = inc_mod60(min_q);
         end
         if (min_carry) begin
            hour_d = inc_mod24(hour_q);
         end
      end else if (set_en && set_inc) begin
         case (sel_e'(set_sel))
            SEL_HOUR: hour_d = inc_mod24(hour_q);
            SEL_MIN:  min_d  = inc_mod60(min_q);
            SEL_SEC:  sec_d  = inc_mod60(sec_q);
            default:  ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hour_q    <= '0;
         min_q     <= '0;
         sec_q     <= '0;
         prescale  <= '0;
         sec_pulse <= 1'b0;
         day_pulse <= 1'b0;
      end else begin
         hour_q    <= hour_d;
         min_q     <= min_d;
         sec_q     <= sec_d;
         prescale  <= prescale_d;
         sec_pulse <= tick;
         day_pulse <= day_wrap;
      end
   end

   assign hour_t = hour_q.t;
   assign hour_u = hour_q.u;
   assign min_t  = min_q.t;
   assign min_u  = min_q.u;
   assign sec_t  = sec_q.t;
   assign sec_u  = sec_q.u;

endmodule

// File: tb/tb_dem_thoi_gian.sv
// Bench for dem_thoi_gian at CLK_HZ=4: seconds-of-day model checked every cycle plus literal expectations.
module tb_dem_thoi_gian;

   localparam int HZ = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       set_en = 1'b0;
   logic [1:0] set_sel = 2'b11;
   logic       set_inc = 1'b0;
   logic [3:0] hour_t, hour_u, min_t, min_u, sec_t, sec_u;
   logic       sec_pulse, day_pulse;

   int checks = 0;
   int failures = 0;

   dem_thoi_gian #(.CLK_HZ(HZ)) dut (
      .clk(clk), .rst_n(rst_n), .set_en(set_en), .set_sel(set_sel), .set_inc(set_inc),
      .hour_t(hour_t), .hour_u(hour_u), .min_t(min_t), .min_u(min_u),
      .sec_t(sec_t), .sec_u(sec_u), .sec_pulse(sec_pulse), .day_pulse(day_pulse)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: time as seconds-of-day plus an integer prescaler count
   int m_secs = 0;
   int m_ps = 0;
   bit m_sp = 0;
   bit m_dp = 0;

   function automatic int adjust(input int secs, input logic [1:0] sel);
      int h, m, s;
      h = secs / 3600;
      m = (secs / 60) % 60;
      s = secs % 60;
      case (sel)
         2'b00: h = (h + 1) % 24;
         2'b01: m = (m + 1) % 60;
         2'b10: s = (s + 1) % 60;
         default: ;
      endcase
      return h * 3600 + m * 60 + s;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_secs <= 0; m_ps <= 0; m_sp <= 0; m_dp <= 0;
      end else if (set_en) begin
         m_ps <= 0; m_sp <= 0; m_dp <= 0;
         if (set_inc) m_secs <= adjust(m_secs, set_sel);
      end else if (m_ps == HZ - 1) begin
         m_ps <= 0;
         m_secs <= (m_secs + 1) % 86400;
         m_sp <= 1;
         m_dp <= (m_secs == 86399);
      end else begin
         m_ps <= m_ps + 1; m_sp <= 0; m_dp <= 0;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         check("m_hour_t", int'(hour_t), (m_secs / 3600) / 10);
         check("m_hour_u", int'(hour_u), (m_secs / 3600) % 10);
         check("m_min_t",  int'(min_t),  ((m_secs / 60) % 60) / 10);
         check("m_min_u",  int'(min_u),  ((m_secs / 60) % 60) % 10);
         check("m_sec_t",  int'(sec_t),  (m_secs % 60) / 10);
         check("m_sec_u",  int'(sec_u),  (m_secs % 60) % 10);
         check("m_sec_pulse", int'(sec_pulse), int'(m_sp));
         check("m_day_pulse", int'(day_pulse), int'(m_dp));
      end
   end

   function automatic int shown();
      return int'(hour_t) * 100000 + int'(hour_u) * 10000 + int'(min_t) * 1000 +
             int'(min_u) * 100 + int'(sec_t) * 10 + int'(sec_u);
   endfunction

   // Holds set_inc for n consecutive edges, then leaves set_en high with set_inc low.
   task automatic set_field(input logic [1:0] sel, input int n);
      @(negedge clk);
      set_en = 1'b1;
      set_sel = sel;
      set_inc = (n > 0);
      repeat (n) @(negedge clk);
      set_inc = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #2;
      check("rst_time", shown(), 0);
      check("rst_sec_pulse", int'(sec_pulse), 0);
      check("rst_day_pulse", int'(day_pulse), 0);

      // first advance on the 4th edge after release, then every 4 edges
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("rel_sec_u_e3", int'(sec_u), 0);
      @(negedge clk);
      check("rel_sec_u_e4", int'(sec_u), 1);
      check("rel_pulse_e4", int'(sec_pulse), 1);
      @(negedge clk);
      check("rel_pulse_e5", int'(sec_pulse), 0);
      repeat (3) @(negedge clk);
      check("rel_sec_u_e8", int'(sec_u), 2);
      check("rel_pulse_e8", int'(sec_pulse), 1);

      // 00:00:59 -> 00:01:00
      do_reset();
      set_field(2'b10, 59);
      check("set_00_00_59", shown(), 59);
      set_en = 1'b0;
      repeat (3) @(negedge clk);
      check("hold_00_00_59", shown(), 59);
      @(negedge clk);
      check("carry_min", shown(), 100);
      check("carry_min_dp", int'(day_pulse), 0);

      // 23:59:59 -> 00:00:00 with day_pulse
      do_reset();
      set_field(2'b00, 23);
      set_field(2'b01, 59);
      set_field(2'b10, 59);
      check("set_23_59_59", shown(), 235959);
      set_en = 1'b0;
      repeat (4) @(negedge clk);
      check("day_wrap_time", shown(), 0);
      check("day_wrap_sp", int'(sec_pulse), 1);
      check("day_wrap_dp", int'(day_pulse), 1);

      // 25 hour increments wrap to 01; minutes untouched; sel=11 and set_en=0 ignored
      do_reset();
      set_field(2'b01, 7);
      set_field(2'b00, 25);
      check("hour_mod24", shown(), 10700);
      set_field(2'b11, 5);
      check("sel_none", shown(), 10700);
      @(negedge clk);
      set_en = 1'b0;
      set_sel = 2'b00;
      set_inc = 1'b1;
      @(negedge clk);
      set_inc = 1'b0;
      check("inc_no_set_en", shown(), 10700);

      // set_en on the tick cycle at 00:00:05 wins
      do_reset();
      set_field(2'b10, 4);
      set_en = 1'b0;
      repeat (4) @(negedge clk);
      check("at_00_00_05", shown(), 5);
      repeat (3) @(negedge clk);
      set_en = 1'b1;
      @(negedge clk);
      check("tick_blocked", shown(), 5);
      check("tick_blocked_sp", int'(sec_pulse), 0);
      repeat (2) @(negedge clk);
      set_en = 1'b0;
      repeat (3) @(negedge clk);
      check("restart_e3", shown(), 5);
      @(negedge clk);
      check("restart_e4", shown(), 6);

      // async reset at 12:34:56 between edges
      do_reset();
      set_field(2'b00, 12);
      set_field(2'b01, 34);
      set_field(2'b10, 56);
      @(negedge clk);
      check("at_12_34_56", shown(), 123456);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_time", shown(), 0);
      check("async_rst_sp", int'(sec_pulse), 0);
      @(negedge clk);
      set_en = 1'b0;
      rst_n = 1'b1;
      repeat (6) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
